// File: rtl/bvh_traverse_ctrl_pkg.sv
// Shared types for the BVH traversal controller: fixed-point vectors, boxes,
// node records and the traversal FSM state encoding.
package bvh_traverse_ctrl_pkg;

  localparam int BVH_NODE_AW = 10;
  localparam int BVH_PRIM_AW = 16;
  localparam int COORD_W     = 24;

  typedef logic signed [COORD_W-1:0] coord_t;

  typedef struct packed {
    coord_t x;
    coord_t y;
    coord_t z;
  } vec3_t;

  typedef struct packed {
    coord_t tmin;
    coord_t tmax;
  } vec2_t;

  typedef struct packed {
    vec3_t lo;
    vec3_t hi;
  } bbox_t;

  typedef struct packed {
    bbox_t                  box;
    logic                   is_leaf;
    logic [BVH_NODE_AW-1:0] left;
    logic [BVH_PRIM_AW-1:0] prim_base;
    logic [3:0]             prim_cnt;
  } bvh_node_t;

  typedef enum logic [2:0] {
    TS_IDLE  = 3'd0,
    TS_FETCH = 3'd1,
    TS_WAIT  = 3'd2,
    TS_TEST  = 3'd3,
    TS_EMIT  = 3'd4,
    TS_POP   = 3'd5,
    TS_DONE  = 3'd6
  } trav_state_t;

  // Siblings are stored adjacently, so the right child always follows the left.
  function automatic logic [BVH_NODE_AW-1:0] right_child(input logic [BVH_NODE_AW-1:0] left);
    return left + 1'b1;
  endfunction

endpackage

// File: rtl/bvh_traverse_ctrl_stack.sv
// Synchronous LIFO holding deferred right-child addresses during traversal.
// A push while full is dropped; a pop while empty is ignored.
module bvh_traverse_ctrl_stack #(
  parameter int STACK_DEPTH = 16,
  parameter int W           = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         empty,
  output logic         full
);

  localparam int PW = $clog2(STACK_DEPTH);

  logic [W-1:0] mem [STACK_DEPTH];
  logic [PW:0]  sp_q;
  logic [PW:0]  sp_dec;

  assign sp_dec = sp_q - 1'b1;
  assign empty  = (sp_q == '0);
  assign full   = (sp_q == (PW+1)'(STACK_DEPTH));
  assign dout   = mem[sp_dec[PW-1:0]];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sp_q <= '0;
    end else if (push && !full) begin
      sp_q <= sp_q + 1'b1;
    end else if (pop && !empty) begin
      sp_q <= sp_dec;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem[sp_q[PW-1:0]] <= din;
    end
  end

endmodule

// File: rtl/bvh_traverse_ctrl.sv
// Depth-first BVH traversal sequencer driving one shared ray/box intersect unit.
// Optional feature macro: TRAV_PERF_CNT_EN adds perf_nodes / perf_leaves counters.
module bvh_traverse_ctrl
  import bvh_traverse_ctrl_pkg::*;
#(
  parameter int NODE_AW     = BVH_NODE_AW,
  parameter int STACK_DEPTH = 16,
  parameter int PRIM_AW     = BVH_PRIM_AW
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ray_valid,
  output logic               ray_ready,
  input  vec3_t              ray_orig,
  input  vec3_t              ray_inv_dir,
  input  vec2_t              ray_range,
  output logic               node_rd_en,
  output logic [NODE_AW-1:0] node_addr,
  input  bvh_node_t          node_data,
  output vec3_t              isect_orig,
  output vec3_t              isect_inv_dir,
  output bbox_t              isect_box,
  output vec2_t              isect_prev_range,
  input  logic               isect_hit,
  input  vec2_t              isect_range,
  output logic               leaf_valid,
  input  logic               leaf_ready,
  output logic [PRIM_AW-1:0] leaf_prim_base,
  output logic [3:0]         leaf_prim_cnt,
  output vec2_t              leaf_range,
  output logic               trav_done,
  output logic               trav_overflow
`ifdef TRAV_PERF_CNT_EN
  ,
  output logic [15:0]        perf_nodes,
  output logic [15:0]        perf_leaves
`endif
);

  localparam logic [2:0] S_IDLE  = TS_IDLE;
  localparam logic [2:0] S_FETCH = TS_FETCH;
  localparam logic [2:0] S_WAIT  = TS_WAIT;
  localparam logic [2:0] S_TEST  = TS_TEST;
  localparam logic [2:0] S_EMIT  = TS_EMIT;
  localparam logic [2:0] S_POP   = TS_POP;
  localparam logic [2:0] S_DONE  = TS_DONE;

  logic [2:0]         state_q;
  logic [NODE_AW-1:0] next_addr_q;
  vec3_t              orig_q;
  vec3_t              inv_q;
  vec2_t              range_q;
  bvh_node_t          node_q;
  vec2_t              hit_range_q;
  logic               ovf_q;

  logic               stk_push;
  logic               stk_pop;
  logic               stk_empty;
  logic               stk_full;
  logic [NODE_AW-1:0] stk_dout;

  // A hit on an internal node defers its right child; the left child is visited next.
  assign stk_push = (state_q == S_TEST) && isect_hit && !node_q.is_leaf;
  assign stk_pop  = (state_q == S_POP) && !stk_empty;

  bvh_traverse_ctrl_stack #(
    .STACK_DEPTH (STACK_DEPTH),
    .W           (NODE_AW)
  ) u_stack (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (stk_push),
    .pop   (stk_pop),
    .din   (right_child(node_q.left)),
    .dout  (stk_dout),
    .empty (stk_empty),
    .full  (stk_full)
  );

  assign ray_ready        = (state_q == S_IDLE);
  assign node_rd_en       = (state_q == S_FETCH);
  assign node_addr        = next_addr_q;
  assign isect_orig       = orig_q;
  assign isect_inv_dir    = inv_q;
  assign isect_box        = node_q.box;
  assign isect_prev_range = range_q;
  assign leaf_valid       = (state_q == S_EMIT);
  assign leaf_prim_base   = node_q.prim_base;
  assign leaf_prim_cnt    = node_q.prim_cnt;
  assign leaf_range       = hit_range_q;
  assign trav_done        = (state_q == S_DONE);
  assign trav_overflow    = (state_q == S_DONE) && ovf_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      next_addr_q <= '0;
      orig_q      <= '0;
      inv_q       <= '0;
      range_q     <= '0;
      node_q      <= '0;
      hit_range_q <= '0;
      ovf_q       <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (ray_valid) begin
            orig_q      <= ray_orig;
            inv_q       <= ray_inv_dir;
            range_q     <= ray_range;
            next_addr_q <= '0;
            ovf_q       <= 1'b0;
            state_q     <= S_FETCH;
          end
        end
        S_FETCH: state_q <= S_WAIT;
        S_WAIT: begin
          node_q  <= node_data;
          state_q <= S_TEST;
        end
        S_TEST: begin
          hit_range_q <= isect_range;
          if (!isect_hit) begin
            state_q <= S_POP;
          end else if (node_q.is_leaf) begin
            state_q <= S_EMIT;
          end else begin
            // A full stack loses the right subtree; remember that for this ray.
            if (stk_full) ovf_q <= 1'b1;
            next_addr_q <= node_q.left;
            state_q     <= S_FETCH;
          end
        end
        S_EMIT: begin
          if (leaf_ready) state_q <= S_POP;
        end
        S_POP: begin
          if (stk_empty) begin
            state_q <= S_DONE;
          end else begin
            next_addr_q <= stk_dout;
            state_q     <= S_FETCH;
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

`ifdef TRAV_PERF_CNT_EN
  logic [15:0] perf_nodes_q;
  logic [15:0] perf_leaves_q;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_nodes_q  <= '0;
      perf_leaves_q <= '0;
    end else if (state_q == S_IDLE && ray_valid) begin
      perf_nodes_q  <= '0;
      perf_leaves_q <= '0;
    end else begin
      if (state_q == S_TEST) perf_nodes_q <= sat_inc(perf_nodes_q);
      if (state_q == S_EMIT && leaf_ready) perf_leaves_q <= sat_inc(perf_leaves_q);
    end
  end

  assign perf_nodes  = perf_nodes_q;
  assign perf_leaves = perf_leaves_q;
`endif

endmodule

// File: tb/tb_bvh_traverse_ctrl.sv
// Self-checking bench for bvh_traverse_ctrl: node memory, slab-test intersect
// stand-in, table vectors, corner sequences and randomized trees vs a DFS model.
module tb_bvh_traverse_ctrl;
  import bvh_traverse_ctrl_pkg::*;

  localparam int SD = 2;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               ray_valid = 1'b0;
  logic               ray_ready;
  vec3_t              ray_orig = '0;
  vec3_t              ray_inv_dir = '0;
  vec2_t              ray_range = '0;
  logic               node_rd_en;
  logic [BVH_NODE_AW-1:0] node_addr;
  bvh_node_t          node_data = '0;
  vec3_t              isect_orig;
  vec3_t              isect_inv_dir;
  bbox_t              isect_box;
  vec2_t              isect_prev_range;
  logic               isect_hit;
  vec2_t              isect_range;
  logic               leaf_valid;
  logic               leaf_ready = 1'b1;
  logic [BVH_PRIM_AW-1:0] leaf_prim_base;
  logic [3:0]         leaf_prim_cnt;
  vec2_t              leaf_range;
  logic               trav_done;
  logic               trav_overflow;
`ifdef TRAV_PERF_CNT_EN
  logic [15:0]        perf_nodes;
  logic [15:0]        perf_leaves;
`endif

  bvh_traverse_ctrl #(.STACK_DEPTH(SD)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .ray_valid        (ray_valid),
    .ray_ready        (ray_ready),
    .ray_orig         (ray_orig),
    .ray_inv_dir      (ray_inv_dir),
    .ray_range        (ray_range),
    .node_rd_en       (node_rd_en),
    .node_addr        (node_addr),
    .node_data        (node_data),
    .isect_orig       (isect_orig),
    .isect_inv_dir    (isect_inv_dir),
    .isect_box        (isect_box),
    .isect_prev_range (isect_prev_range),
    .isect_hit        (isect_hit),
    .isect_range      (isect_range),
    .leaf_valid       (leaf_valid),
    .leaf_ready       (leaf_ready),
    .leaf_prim_base   (leaf_prim_base),
    .leaf_prim_cnt    (leaf_prim_cnt),
    .leaf_range       (leaf_range),
    .trav_done        (trav_done),
    .trav_overflow    (trav_overflow)
`ifdef TRAV_PERF_CNT_EN
    ,
    .perf_nodes       (perf_nodes),
    .perf_leaves      (perf_leaves)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed { logic hit; vec2_t r; } ires_t;
  typedef struct packed { logic [15:0] base; logic [3:0] cnt; vec2_t rng; } leaf_t;

  bvh_node_t mem [1024];
  ires_t     ir;

  always_ff @(posedge clk) begin
    if (node_rd_en) node_data <= mem[node_addr];
  end

  // Slab test: entry = max of per-axis near planes and tmin, exit = min of far planes and tmax.
  function automatic ires_t slab(input bbox_t b, input vec3_t o, input vec3_t inv, input vec2_t pr);
    longint lo [3];
    longint hi [3];
    longint oo [3];
    longint ii [3];
    longint t0, t1, tn, tf, tmp;
    ires_t  res;
    lo[0] = longint'($signed(b.lo.x)); lo[1] = longint'($signed(b.lo.y)); lo[2] = longint'($signed(b.lo.z));
    hi[0] = longint'($signed(b.hi.x)); hi[1] = longint'($signed(b.hi.y)); hi[2] = longint'($signed(b.hi.z));
    oo[0] = longint'($signed(o.x));    oo[1] = longint'($signed(o.y));    oo[2] = longint'($signed(o.z));
    ii[0] = longint'($signed(inv.x));  ii[1] = longint'($signed(inv.y));  ii[2] = longint'($signed(inv.z));
    tn = longint'($signed(pr.tmin));
    tf = longint'($signed(pr.tmax));
    for (int a = 0; a < 3; a++) begin
      t0 = (lo[a] - oo[a]) * ii[a];
      t1 = (hi[a] - oo[a]) * ii[a];
      if (t0 > t1) begin tmp = t0; t0 = t1; t1 = tmp; end
      if (t0 > tn) tn = t0;
      if (t1 < tf) tf = t1;
    end
    res.hit    = (tn <= tf);
    res.r.tmin = tn[23:0];
    res.r.tmax = tf[23:0];
    return res;
  endfunction

  always_comb ir = slab(isect_box, isect_orig, isect_inv_dir, isect_prev_range);
  assign isect_hit   = ir.hit;
  assign isect_range = ir.r;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  function automatic vec3_t v3(input int x, input int y, input int z);
    vec3_t v;
    v.x = coord_t'(x); v.y = coord_t'(y); v.z = coord_t'(z);
    return v;
  endfunction

  function automatic vec2_t v2(input int a, input int b);
    vec2_t v;
    v.tmin = coord_t'(a); v.tmax = coord_t'(b);
    return v;
  endfunction

  function automatic bvh_node_t mk_node(input int lo, input int hi, input bit leaf,
                                        input int left, input int base, input int cnt);
    bvh_node_t n;
    n.box.lo    = v3(lo, lo, lo);
    n.box.hi    = v3(hi, hi, hi);
    n.is_leaf   = leaf;
    n.left      = BVH_NODE_AW'(left);
    n.prim_base = BVH_PRIM_AW'(base);
    n.prim_cnt  = 4'(cnt);
    return n;
  endfunction

  task automatic load_three();
    mem[0] = mk_node(0, 100, 1'b0, 1, 0, 0);
    mem[1] = mk_node(0, 40, 1'b1, 0, 0, 3);
    mem[2] = mk_node(60, 100, 1'b1, 0, 8, 5);
  endtask

  task automatic load_deep();
    mem[0] = mk_node(0, 100, 1'b0, 1, 0, 0);
    mem[1] = mk_node(0, 100, 1'b0, 3, 0, 0);
    mem[2] = mk_node(0, 100, 1'b1, 0, 2, 1);
    mem[3] = mk_node(0, 100, 1'b0, 5, 0, 0);
    mem[4] = mk_node(0, 100, 1'b1, 0, 4, 1);
    mem[5] = mk_node(0, 100, 1'b0, 7, 0, 0);
    mem[6] = mk_node(0, 100, 1'b1, 0, 6, 1);
    mem[7] = mk_node(0, 100, 1'b1, 0, 7, 1);
    mem[8] = mk_node(0, 100, 1'b1, 0, 8, 1);
  endtask

  task automatic gen_tree(input int max_nodes);
    int        pend [$];
    int        alloc;
    int        a;
    int        lo;
    bvh_node_t n;
    pend.push_back(0);
    alloc = 1;
    while (pend.size() > 0) begin
      a  = pend.pop_front();
      n  = '0;
      lo = int'($urandom_range(0, 80)); n.box.lo.x = coord_t'(lo); n.box.hi.x = coord_t'(lo + int'($urandom_range(10, 100)));
      lo = int'($urandom_range(0, 80)); n.box.lo.y = coord_t'(lo); n.box.hi.y = coord_t'(lo + int'($urandom_range(10, 100)));
      lo = int'($urandom_range(0, 80)); n.box.lo.z = coord_t'(lo); n.box.hi.z = coord_t'(lo + int'($urandom_range(10, 100)));
      if (alloc + 2 <= max_nodes && $urandom_range(0, 2) != 0) begin
        n.is_leaf = 1'b0;
        n.left    = BVH_NODE_AW'(alloc);
        pend.push_back(alloc);
        pend.push_back(alloc + 1);
        alloc += 2;
      end else begin
        n.is_leaf   = 1'b1;
        n.prim_base = BVH_PRIM_AW'($urandom);
        n.prim_cnt  = 4'($urandom);
      end
      mem[a] = n;
    end
  endtask

  // Reference traversal: plain DFS with a bounded list of deferred right children.
  leaf_t exp_q [$];
  bit    m_ovf;
  int    m_nodes;

  task automatic model(input vec3_t o, input vec3_t inv, input vec2_t pr);
    int        stk [$];
    int        addr;
    ires_t     r;
    bvh_node_t n;
    exp_q.delete();
    m_ovf = 0; m_nodes = 0; addr = 0;
    for (int it = 0; it < 5000; it++) begin
      n = mem[addr];
      r = slab(n.box, o, inv, pr);
      m_nodes++;
      if (r.hit && !n.is_leaf) begin
        if (stk.size() < SD) stk.push_back(int'(n.left) + 1);
        else m_ovf = 1;
        addr = int'(n.left);
      end else begin
        if (r.hit) exp_q.push_back('{n.prim_base, n.prim_cnt, r.r});
        if (stk.size() == 0) break;
        addr = stk.pop_back();
      end
    end
  endtask

  leaf_t got_q [$];
  bit    got_ovf;
  bit    got_done;
  int    got_cycles;

  task automatic start_ray(input vec3_t o, input vec3_t inv, input vec2_t pr);
    @(negedge clk);
    chk("ray_ready_idle", longint'(ray_ready), 1);
    ray_orig = o; ray_inv_dir = inv; ray_range = pr; ray_valid = 1'b1;
    @(negedge clk);
    ray_valid = 1'b0;
  endtask

  task automatic run_ray(input vec3_t o, input vec3_t inv, input vec2_t pr, input bit rnd_ready);
    got_q.delete();
    got_ovf = 0; got_done = 0;
    start_ray(o, inv, pr);
    got_cycles = 1;
    for (int c = 0; c < 3000; c++) begin
      leaf_ready = rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (leaf_valid && leaf_ready) got_q.push_back('{leaf_prim_base, leaf_prim_cnt, leaf_range});
      if (trav_done) begin
        got_done = 1;
        got_ovf  = trav_overflow;
        break;
      end
      @(negedge clk);
      got_cycles++;
    end
    leaf_ready = 1'b1;
    chk("trav_done_seen", longint'(got_done), 1);
  endtask

  task automatic compare_model();
    int n;
    chk("leaf_count", got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      chk("leaf_base", longint'(got_q[i].base), longint'(exp_q[i].base));
      chk("leaf_cnt", longint'(got_q[i].cnt), longint'(exp_q[i].cnt));
      chk("leaf_range", longint'(got_q[i].rng), longint'(exp_q[i].rng));
    end
    chk("overflow", longint'(got_ovf), longint'(m_ovf));
`ifdef TRAV_PERF_CNT_EN
    chk("perf_nodes", longint'(perf_nodes), longint'(m_nodes));
    chk("perf_leaves", longint'(perf_leaves), longint'(exp_q.size()));
`endif
  endtask

  typedef struct {
    int tmin; int tmax; int n; int b0; int b1; int r0min; int r0max; int cyc;
  } tvec_t;

  tvec_t tv [6];

  initial begin
    leaf_t snap;
    bit    found;

    tv[0] = '{0,    1000, 2, 0, 8, 0,  40,  14};
    tv[1] = '{0,    50,   1, 0, 0, 0,  40,  13};
    tv[2] = '{50,   1000, 1, 8, 0, 60, 100, 13};
    tv[3] = '{200,  300,  0, 0, 0, 0,  0,   5};
    tv[4] = '{40,   60,   2, 0, 8, 40, 40,  14};
    tv[5] = '{41,   59,   0, 0, 0, 0,  0,   12};

    for (int i = 0; i < 1024; i++) mem[i] = '0;
    repeat (3) @(negedge clk);
    chk("rst_ray_ready", longint'(ray_ready), 1);
    chk("rst_node_rd_en", longint'(node_rd_en), 0);
    chk("rst_leaf_valid", longint'(leaf_valid), 0);
    chk("rst_trav_done", longint'(trav_done), 0);
    chk("rst_overflow", longint'(trav_overflow), 0);
    chk("rst_isect_box", longint'(isect_box.hi.x), 0);
    rst_n = 1'b1;

    // Root miss.
    mem[0] = mk_node(10, 20, 1'b0, 1, 0, 0);
    run_ray(v3(0, 0, 0), v3(1, 1, 1), v2(0, 5), 1'b0);
    chk("rootmiss_cycles", got_cycles, 5);
    chk("rootmiss_leaves", got_q.size(), 0);
    chk("rootmiss_ovf", longint'(got_ovf), 0);

    // Table vectors on the 3-node tree.
    load_three();
    for (int i = 0; i < 6; i++) begin
      run_ray(v3(0, 0, 0), v3(1, 1, 1), v2(tv[i].tmin, tv[i].tmax), 1'b0);
      chk("tv_leaf_count", got_q.size(), tv[i].n);
      chk("tv_cycles", got_cycles, tv[i].cyc);
      chk("tv_ovf", longint'(got_ovf), 0);
      if (got_q.size() >= 1 && tv[i].n >= 1) begin
        chk("tv_base0", longint'(got_q[0].base), tv[i].b0);
        chk("tv_r0min", longint'($signed(got_q[0].rng.tmin)), tv[i].r0min);
        chk("tv_r0max", longint'($signed(got_q[0].rng.tmax)), tv[i].r0max);
      end
      if (got_q.size() >= 2 && tv[i].n >= 2) chk("tv_base1", longint'(got_q[1].base), tv[i].b1);
`ifdef TRAV_PERF_CNT_EN
      if (i == 0) begin
        chk("perf_nodes_3node", longint'(perf_nodes), 3);
        chk("perf_leaves_3node", longint'(perf_leaves), 2);
      end
`endif
    end

    // Leaf backpressure: hold leaf_ready low for 4 cycles at the first leaf.
    start_ray(v3(0, 0, 0), v3(1, 1, 1), v2(0, 1000));
    leaf_ready = 1'b0;
    found = 0;
    for (int c = 0; c < 50 && !found; c++) begin
      if (leaf_valid) found = 1;
      else @(negedge clk);
    end
    chk("bp_leaf_seen", longint'(found), 1);
    snap = '{leaf_prim_base, leaf_prim_cnt, leaf_range};
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("bp_valid_held", longint'(leaf_valid), 1);
      chk("bp_fields_stable", longint'({leaf_prim_base, leaf_prim_cnt, leaf_range}), longint'(snap));
      chk("bp_no_rd_en", longint'(node_rd_en), 0);
    end
    leaf_ready = 1'b1;
    found = 0;
    for (int c = 0; c < 50 && !found; c++) begin
      @(negedge clk);
      if (trav_done) found = 1;
    end
    chk("bp_done", longint'(found), 1);

    // Stack overflow on a left-deep tree.
    load_deep();
    model(v3(0, 0, 0), v3(1, 1, 1), v2(0, 1000));
    run_ray(v3(0, 0, 0), v3(1, 1, 1), v2(0, 1000), 1'b0);
    chk("deep_ovf", longint'(got_ovf), 1);
    chk("deep_leaves", got_q.size(), 3);
    compare_model();

    // Reset while in TEST abandons the ray.
    load_three();
    start_ray(v3(0, 0, 0), v3(1, 1, 1), v2(0, 1000));
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_ray_ready", longint'(ray_ready), 1);
    chk("midrst_leaf_valid", longint'(leaf_valid), 0);
    chk("midrst_done", longint'(trav_done), 0);
    rst_n = 1'b1;
    run_ray(v3(0, 0, 0), v3(1, 1, 1), v2(0, 1000), 1'b0);
    chk("postrst_leaves", got_q.size(), 2);
    chk("postrst_cycles", got_cycles, 14);

    // Randomized trees and rays against the reference traversal.
    for (int t = 0; t < 8; t++) begin
      gen_tree(int'($urandom_range(1, 31)));
      for (int r = 0; r < 6; r++) begin
        vec3_t o, inv;
        vec2_t pr;
        int    s [3];
        for (int a = 0; a < 3; a++) s[a] = ($urandom_range(0, 1) == 1) ? 1 : -1;
        o   = v3(int'($urandom_range(0, 100)), int'($urandom_range(0, 100)), int'($urandom_range(0, 100)));
        inv = v3(s[0] * int'($urandom_range(1, 2)), s[1] * int'($urandom_range(1, 2)), s[2] * int'($urandom_range(1, 2)));
        pr  = v2(int'($urandom_range(0, 40)) - 20, int'($urandom_range(60, 400)));
        model(o, inv, pr);
        run_ray(o, inv, pr, 1'b1);
        compare_model();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
